seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 128 ++++++++++++
 tb/tb_seq_divider.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential signed 32-bit restoring divider: quotient on LO, remainder on HI, one-cycle fim pulse.
// Optional macro SEQ_DIVIDER_DIVZERO_EN short-circuits B==0 to an immediate DividedByZero completion.
module seq_divider (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] LO,
   output logic [31:0] HI,
   output logic        fim,
   output logic        DividedByZero,
   output logic        busy
);

   localparam int unsigned Width  = 32;
   localparam int unsigned CountW = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } stateT;

   stateT state, nextState;

   logic [Width-1:0]  remReg, quoReg, divMag;
   logic [Width-1:0]  absA, absB;
   logic [CountW-1:0] count;
   logic              signQ, signR;
   logic [Width:0]    shifted, trial;
   logic              busyNext, fimNext, dbzNext;

   // Operand magnitudes; the most negative value maps onto 0x80000000 unchanged
   always_comb begin
      absA = A[Width-1] ? Width'(~A + Width'(1)) : A;
      absB = B[Width-1] ? Width'(~B + Width'(1)) : B;
   end

   // Shift in the next dividend bit and trial-subtract at 33 bits; bit 32 set means negative
   always_comb begin
      shifted = {remReg, quoReg[Width-1]};
      trial   = shifted - {1'b0, divMag};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      dbzNext   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef SEQ_DIVIDER_DIVZERO_EN
               if (B == '0) begin
                  nextState = DONE;
                  dbzNext   = 1'b1;
               end else begin
                  nextState = RUN;
               end
`else
               nextState = RUN;
`endif
            end
         end
         RUN:     if (count == CountW'(Width - 1)) nextState = FIX;
         FIX:     nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
      busyNext = (nextState != IDLE);
      fimNext  = (nextState == DONE);
   end

   // Status outputs registered from the upcoming state so they line up with it
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy          <= 1'b0;
         fim           <= 1'b0;
         DividedByZero <= 1'b0;
      end else begin
         busy          <= busyNext;
         fim           <= fimNext;
         DividedByZero <= dbzNext;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         remReg <= '0;
         quoReg <= '0;
         divMag <= '0;
         count  <= '0;
         signQ  <= 1'b0;
         signR  <= 1'b0;
         LO     <= '0;
         HI     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  remReg <= '0;
                  quoReg <= absA;
                  divMag <= absB;
                  signQ  <= A[Width-1] ^ B[Width-1];
                  signR  <= A[Width-1];
                  count  <= '0;
               end
            end
            RUN: begin
               remReg <= trial[Width] ? shifted[Width-1:0] : trial[Width-1:0];
               quoReg <= {quoReg[Width-2:0], ~trial[Width]};
               count  <= count + CountW'(1);
            end
            FIX: begin
               LO <= signQ ? Width'(~quoReg + Width'(1)) : quoReg;
               HI <= signR ? Width'(~remReg + Width'(1)) : remReg;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed sign/boundary cases plus random operands
// checked against a 64-bit arithmetic reference; honours SEQ_DIVIDER_DIVZERO_EN.
module tb_seq_divider;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] A, B;
   logic [31:0] LO, HI;
   logic        fim, DividedByZero, busy;

   int tests = 0;
   int fails = 0;
   logic [31:0] prevLo = '0;
   logic [31:0] prevHi = '0;

   seq_divider dut (
      .clock(clock), .reset(reset), .start(start), .A(A), .B(B),
      .LO(LO), .HI(HI), .fim(fim), .DividedByZero(DividedByZero), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: truncating signed division computed in 64 bits
   task automatic model(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] lo, output logic [31:0] hi,
                        output logic dbz, output int lat);
      longint la, lb, lq, lr;
      if (b == 32'd0) begin
`ifdef SEQ_DIVIDER_DIVZERO_EN
         lo = prevLo; hi = prevHi; dbz = 1'b1; lat = 1;
`else
         lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF; hi = a; dbz = 1'b0; lat = 34;
`endif
      end else begin
         la = longint'($signed(a));
         lb = longint'($signed(b));
         lq = la / lb;
         lr = la % lb;
         lo = lq[31:0]; hi = lr[31:0]; dbz = 1'b0; lat = 34;
      end
   endtask

   // Entered and left #1 after a rising edge with the DUT idle
   task automatic doOp(input string tag, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] expLo, expHi;
      logic        expDbz;
      int          expLat, cyc;
      model(a, b, expLo, expHi, expDbz, expLat);
      A = a; B = b; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      cyc = 1;
      chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
      while (fim !== 1'b1 && cyc < 40) begin
         @(posedge clock); #1;
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(expLat));
      chk({tag, "_lo"}, LO, expLo);
      chk({tag, "_hi"}, HI, expHi);
      chk({tag, "_dbz"}, 32'(DividedByZero), 32'(expDbz));
      prevLo = expLo; prevHi = expHi;
      @(posedge clock); #1;
      chk({tag, "_fim_off"}, 32'(fim), 32'd0);
      chk({tag, "_busy_off"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      bit          sawFim;
      reset = 1'b1; start = 1'b0; A = '0; B = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_lo", LO, 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_fim", 32'(fim), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      doOp("p100_p7", 32'd100, 32'd7);
      doOp("m100_p7", -32'sd100, 32'd7);
      doOp("p100_m7", 32'd100, -32'sd7);
      doOp("min_m1", 32'h8000_0000, 32'hFFFF_FFFF);
      doOp("p5_p9", 32'd5, 32'd9);
      doOp("m100_m7", -32'sd100, -32'sd7);
      doOp("div0_p42", 32'd42, 32'd0);
      doOp("div0_m42", -32'sd42, 32'd0);

      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) rb = -rb;
         doOp("rand", ra, rb);
      end

      // start held high: first run ignores operand changes, DONE ignores start
      A = 32'd9; B = 32'd2; start = 1'b1;
      for (int cyc = 1; cyc <= 70; cyc++) begin
         @(posedge clock); #1;
         if (cyc == 10) begin A = 32'd1000; B = 32'd7; end
         if (cyc == 40) start = 1'b0;
         chk("held_fim", 32'(fim), 32'((cyc == 34) || (cyc == 69)));
         if (cyc == 34) begin
            chk("held_lo1", LO, 32'd4);
            chk("held_hi1", HI, 32'd1);
         end
         if (cyc == 69) begin
            chk("held_lo2", LO, 32'd142);
            chk("held_hi2", HI, 32'd6);
         end
      end
      prevLo = 32'd142; prevHi = 32'd6;

      // Reset mid-run clears everything asynchronously and suppresses fim
      A = 32'd777; B = 32'd5; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (19) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_lo", LO, 32'd0);
      chk("arst_hi", HI, 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_fim", 32'(fim), 32'd0);
      chk("arst_dbz", 32'(DividedByZero), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      prevLo = '0; prevHi = '0;
      sawFim = 1'b0;
      repeat (40) begin
         @(posedge clock); #1;
         if (fim !== 1'b0) sawFim = 1'b1;
      end
      chk("arst_no_fim", 32'(sawFim), 32'd0);
      doOp("post_rst", 32'd1234, -32'sd5);
      doOp("post_rst_div0", 32'd42, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
